// File: rtl/cfr_output_monitor_pkg.sv
// rtl/cfr_output_monitor_pkg.sv - shared types and widths for the CFR output monitor
package cfr_pkg;

  localparam int DataWidth   = 16;
  localparam int PowerWidth  = 2 * DataWidth;
  localparam int WindowWidth = 24;
  localparam int CountWidth  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cfr_output_monitor_if.sv
// rtl/cfr_output_monitor_if.sv - sample, control and statistics bundle for the CFR output monitor
interface cfr_output_monitor_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int WINDOW_WIDTH = 24,
  parameter int COUNT_WIDTH  = 24
);

  logic signed [DATA_WIDTH-1:0]   data_i_in;
  logic signed [DATA_WIDTH-1:0]   data_q_in;
  logic                           ctrl_enable;
  logic                           ctrl_continuous;
  logic        [DATA_WIDTH:0]     ctrl_threshold;
  logic        [WINDOW_WIDTH-1:0] ctrl_window_len;
  logic                           ctrl_clear;
  logic                           stat_valid;
  logic        [COUNT_WIDTH-1:0]  stat_over_count;
  logic        [2*DATA_WIDTH-1:0] stat_peak_power;
  logic        [15:0]             stat_window_cnt;
  logic                           stat_busy;

  modport master (
    output data_i_in, data_q_in, ctrl_enable, ctrl_continuous,
           ctrl_threshold, ctrl_window_len, ctrl_clear,
    input  stat_valid, stat_over_count, stat_peak_power, stat_window_cnt, stat_busy
  );

  modport slave (
    input  data_i_in, data_q_in, ctrl_enable, ctrl_continuous,
           ctrl_threshold, ctrl_window_len, ctrl_clear,
    output stat_valid, stat_over_count, stat_peak_power, stat_window_cnt, stat_busy
  );

endinterface

// File: rtl/cfr_output_monitor_power_calc.sv
// rtl/cfr_output_monitor_power_calc.sv - 3-stage I^2+Q^2 instantaneous power pipeline
module cfr_power_calc
  import cfr_pkg::*;
#(
  parameter int DATA_WIDTH = DataWidth
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [DATA_WIDTH-1:0]   data_i,
  input  logic signed [DATA_WIDTH-1:0]   data_q,
  output logic        [2*DATA_WIDTH-1:0] power
);

  localparam int PowW = 2 * DATA_WIDTH;
  localparam int SqW  = 2 * DATA_WIDTH - 1;

  logic signed [DATA_WIDTH-1:0] s1_i, s1_q;
  logic signed [PowW-1:0]       i_ext, q_ext;
  logic        [SqW-1:0]        i_sq, q_sq;

  // Squares of signed values never exceed 2^(2W-2), so the top product bit is always zero.
  assign i_ext = {{DATA_WIDTH{s1_i[DATA_WIDTH-1]}}, s1_i};
  assign q_ext = {{DATA_WIDTH{s1_q[DATA_WIDTH-1]}}, s1_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_i  <= '0;
      s1_q  <= '0;
      i_sq  <= '0;
      q_sq  <= '0;
      power <= '0;
    end else begin
      s1_i  <= data_i;
      s1_q  <= data_q;
      i_sq  <= SqW'($unsigned(i_ext * i_ext));
      q_sq  <= SqW'($unsigned(q_ext * q_ext));
      power <= {1'b0, i_sq} + {1'b0, q_sq};
    end
  end

endmodule

// File: rtl/cfr_output_monitor.sv
// rtl/cfr_output_monitor.sv - windowed threshold-exceedance and peak-power monitor on CFR output
module cfr_output_monitor
  import cfr_pkg::*;
#(
  parameter int DATA_WIDTH   = DataWidth,
  parameter int WINDOW_WIDTH = WindowWidth,
  parameter int COUNT_WIDTH  = CountWidth
) (
  input logic             clk,
  input logic             rst_n,
  cfr_output_monitor_if.slave mon
);

  localparam int PowW = 2 * DATA_WIDTH;
  localparam int ThrW = 2 * DATA_WIDTH + 2;

  state_t state, next_state;

  logic [PowW-1:0]         power_s3, power_s4;
  logic                    over_s4;
  logic [DATA_WIDTH:0]     thr_r;
  logic [ThrW-1:0]         thr_sq;
  logic [WINDOW_WIDTH-1:0] win_len_r, sample_cnt;
  logic [COUNT_WIDTH-1:0]  over_acc, over_next;
  logic [PowW-1:0]         peak_acc, peak_next;
  logic                    last, start_win, restart_win, publish;
  logic                    valid_r;
  logic [COUNT_WIDTH-1:0]  over_r;
  logic [PowW-1:0]         peak_r;
  logic [15:0]             wcnt_r;

  cfr_power_calc #(.DATA_WIDTH(DATA_WIDTH)) u_power_calc (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (mon.data_i_in),
    .data_q (mon.data_q_in),
    .power  (power_s3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_r    <= '0;
      thr_sq   <= '0;
      power_s4 <= '0;
      over_s4  <= 1'b0;
    end else begin
      thr_r    <= mon.ctrl_threshold;
      thr_sq   <= ThrW'(thr_r) * ThrW'(thr_r);
      power_s4 <= power_s3;
      over_s4  <= {2'b00, power_s3} > thr_sq;
    end
  end

  assign last      = (sample_cnt == win_len_r - WINDOW_WIDTH'(1));
  assign over_next = (over_s4 && over_acc != '1) ? over_acc + COUNT_WIDTH'(1) : over_acc;
  assign peak_next = (power_s4 > peak_acc) ? power_s4 : peak_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_win   = 1'b0;
    restart_win = 1'b0;
    publish     = 1'b0;
    if (mon.ctrl_clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (mon.ctrl_enable && mon.ctrl_window_len != '0) begin
            next_state = RUN;
            start_win  = 1'b1;
          end
        end
        RUN: begin
          if (!mon.ctrl_enable) begin
            next_state = IDLE;
          end else if (last) begin
            publish = 1'b1;
            if (!mon.ctrl_continuous)             next_state  = DONE;
            else if (mon.ctrl_window_len == '0)   next_state  = IDLE;
            else                                  restart_win = 1'b1;
          end
        end
        DONE: begin
          if (!mon.ctrl_enable) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len_r  <= '0;
      sample_cnt <= '0;
      over_acc   <= '0;
      peak_acc   <= '0;
      valid_r    <= 1'b0;
      over_r     <= '0;
      peak_r     <= '0;
      wcnt_r     <= '0;
    end else if (mon.ctrl_clear) begin
      sample_cnt <= '0;
      over_acc   <= '0;
      peak_acc   <= '0;
      valid_r    <= 1'b0;
      over_r     <= '0;
      peak_r     <= '0;
      wcnt_r     <= '0;
    end else begin
      valid_r <= publish;
      // A restart shares the edge with publish, so the new window starts with no gap.
      if (start_win || restart_win) begin
        win_len_r  <= mon.ctrl_window_len;
        sample_cnt <= '0;
        over_acc   <= '0;
        peak_acc   <= '0;
      end else if (state == RUN && mon.ctrl_enable) begin
        sample_cnt <= sample_cnt + WINDOW_WIDTH'(1);
        over_acc   <= over_next;
        peak_acc   <= peak_next;
      end
      if (publish) begin
        over_r <= over_next;
        peak_r <= peak_next;
        wcnt_r <= wcnt_r + 16'd1;
      end
    end
  end

  assign mon.stat_valid      = valid_r;
  assign mon.stat_over_count = over_r;
  assign mon.stat_peak_power = peak_r;
  assign mon.stat_window_cnt = wcnt_r;
  assign mon.stat_busy       = (state == RUN);

endmodule

// File: tb/tb_cfr_output_monitor.sv
// tb/tb_cfr_output_monitor.sv - directed self-checking bench for cfr_output_monitor
module tb_cfr_output_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cfr_output_monitor_if #(.DATA_WIDTH(16), .WINDOW_WIDTH(24), .COUNT_WIDTH(24)) bus ();
  cfr_output_monitor_if #(.DATA_WIDTH(16), .WINDOW_WIDTH(24), .COUNT_WIDTH(4))  sat_bus ();

  assign sat_bus.data_i_in       = bus.data_i_in;
  assign sat_bus.data_q_in       = bus.data_q_in;
  assign sat_bus.ctrl_enable     = bus.ctrl_enable;
  assign sat_bus.ctrl_continuous = bus.ctrl_continuous;
  assign sat_bus.ctrl_threshold  = bus.ctrl_threshold;
  assign sat_bus.ctrl_window_len = bus.ctrl_window_len;
  assign sat_bus.ctrl_clear      = bus.ctrl_clear;

  cfr_output_monitor #(.DATA_WIDTH(16), .WINDOW_WIDTH(24), .COUNT_WIDTH(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  cfr_output_monitor #(.DATA_WIDTH(16), .WINDOW_WIDTH(24), .COUNT_WIDTH(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (sat_bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.stat_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic setup(input logic signed [15:0] i, input logic signed [15:0] q,
                       input logic [16:0] thr, input logic [23:0] len, input logic cont);
    bus.data_i_in       = i;
    bus.data_q_in       = q;
    bus.ctrl_threshold  = thr;
    bus.ctrl_window_len = len;
    bus.ctrl_continuous = cont;
    repeat (8) @(negedge clk);
  endtask

  int n, bad, cnt;

  initial begin
    rst_n               = 1'b0;
    bus.data_i_in       = '0;
    bus.data_q_in       = '0;
    bus.ctrl_enable     = 1'b0;
    bus.ctrl_continuous = 1'b0;
    bus.ctrl_threshold  = '0;
    bus.ctrl_window_len = '0;
    bus.ctrl_clear      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.stat_valid || bus.stat_busy || bus.stat_over_count != 0 ||
          bus.stat_peak_power != 0 || bus.stat_window_cnt != 0) bad++;
    end
    check("reset_quiet_cycles", bad, 0);
    check("reset_over", bus.stat_over_count, 0);
    check("reset_peak", bus.stat_peak_power, 0);
    check("reset_wcnt", bus.stat_window_cnt, 0);

    bus.ctrl_enable = 1'b1;
    repeat (5) @(negedge clk);
    check("len0_stays_idle", bus.stat_busy, 0);
    bus.ctrl_enable = 1'b0;

    // 0x4000^2 * 2 = 0x20000000, above 0x5000^2 = 0x19000000
    setup(16'sh4000, 16'sh4000, 17'h05000, 24'd8, 1'b1);
    bus.ctrl_enable = 1'b1;
    wait_valid(20, n);
    check("cont_first_latency", n, 9);
    check("cont_busy", bus.stat_busy, 1);
    check("cont_over_w1", bus.stat_over_count, 8);
    check("cont_peak_w1", bus.stat_peak_power, 64'h2000_0000);
    check("cont_wcnt_w1", bus.stat_window_cnt, 1);
    for (int w = 2; w <= 3; w++) begin
      wait_valid(20, n);
      check("cont_period", n, 8);
      check("cont_over", bus.stat_over_count, 8);
      check("cont_wcnt", bus.stat_window_cnt, w);
    end
    bus.ctrl_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("cont_stop_busy", bus.stat_busy, 0);
    check("cont_stop_wcnt", bus.stat_window_cnt, 3);

    // power equals thr^2: not an exceedance
    setup(16'sd1000, 16'sd0, 17'd1000, 24'd16, 1'b0);
    bus.ctrl_enable = 1'b1;
    wait_valid(30, n);
    check("eq_latency", n, 17);
    check("eq_over", bus.stat_over_count, 0);
    check("eq_peak", bus.stat_peak_power, 1000000);
    check("eq_wcnt", bus.stat_window_cnt, 4);
    @(negedge clk);
    check("eq_valid_single", bus.stat_valid, 0);
    check("eq_done_busy", bus.stat_busy, 0);
    bus.ctrl_enable = 1'b0;
    repeat (2) @(negedge clk);

    setup(-16'sd32768, -16'sd32768, 17'd0, 24'd4, 1'b1);
    bus.ctrl_enable = 1'b1;
    wait_valid(20, n);
    check("max_latency", n, 5);
    check("max_peak", bus.stat_peak_power, 64'h8000_0000);
    check("max_over", bus.stat_over_count, 4);
    check("max_wcnt", bus.stat_window_cnt, 5);
    bus.ctrl_enable = 1'b0;
    repeat (2) @(negedge clk);

    // 100^2 * 2 = 20000 > 10000
    setup(16'sd100, 16'sd100, 17'd100, 24'd10, 1'b0);
    bus.ctrl_enable = 1'b1;
    wait_valid(30, n);
    check("oneshot_latency", n, 11);
    check("oneshot_over", bus.stat_over_count, 10);
    check("oneshot_peak", bus.stat_peak_power, 20000);
    check("oneshot_wcnt", bus.stat_window_cnt, 6);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.stat_valid) cnt++;
    end
    check("oneshot_no_repeat", cnt, 0);
    check("oneshot_done_busy", bus.stat_busy, 0);
    check("oneshot_stable", bus.stat_over_count, 10);
    bus.ctrl_clear = 1'b1;
    @(negedge clk);
    bus.ctrl_clear = 1'b0;
    check("clear_over", bus.stat_over_count, 0);
    check("clear_peak", bus.stat_peak_power, 0);
    check("clear_wcnt", bus.stat_window_cnt, 0);
    check("clear_busy", bus.stat_busy, 0);
    @(negedge clk);
    check("clear_restart_busy", bus.stat_busy, 1);
    wait_valid(20, n);
    check("clear_restart_latency", n, 10);
    check("clear_restart_over", bus.stat_over_count, 10);
    check("clear_restart_wcnt", bus.stat_window_cnt, 1);
    bus.ctrl_enable = 1'b0;
    repeat (2) @(negedge clk);

    bus.ctrl_window_len = 24'd20;
    bus.ctrl_continuous = 1'b1;
    bus.ctrl_enable     = 1'b1;
    repeat (5) @(negedge clk);
    bus.ctrl_enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.stat_valid || sat_bus.stat_valid) cnt++;
    end
    check("abort_no_valid", cnt, 0);
    check("abort_over_kept", bus.stat_over_count, 10);
    check("abort_peak_kept", bus.stat_peak_power, 20000);
    check("abort_wcnt_kept", bus.stat_window_cnt, 1);
    check("abort_sat_over_kept", sat_bus.stat_over_count, 10);
    bus.ctrl_enable = 1'b1;
    wait_valid(40, n);
    check("full20_latency", n, 21);
    check("full20_over", bus.stat_over_count, 20);
    check("sat_over", sat_bus.stat_over_count, 15);
    check("sat_peak", sat_bus.stat_peak_power, 20000);
    check("sat_wcnt", sat_bus.stat_window_cnt, 2);
    bus.ctrl_enable = 1'b0;
    repeat (2) @(negedge clk);

    bus.ctrl_window_len = 24'd1;
    bus.ctrl_enable     = 1'b1;
    wait_valid(10, n);
    check("len1_latency", n, 2);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.stat_valid) cnt++;
    end
    check("len1_valid_every_cycle", cnt, 10);
    check("len1_over", bus.stat_over_count, 1);
    check("len1_wcnt", bus.stat_window_cnt, 13);
    bus.ctrl_enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
